// File: rtl/axis_fifo_pkg.sv
// Shared types and helpers for the AXI Stream frame FIFO.
package axis_fifo_pkg;

    // Write-side state: accept beats into memory, or discard the rest of a frame.
    typedef enum logic [0:0] {
        WR_PASS = 1'b0,
        WR_DROP = 1'b1
    } wr_state_e;

    // Modulo-2^pw subtraction of two pointers carried in 32-bit containers.
    function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int unsigned pw);
        logic [31:0] mask;
        mask = (32'd1 << pw) - 32'd1;
        return (a - b) & mask;
    endfunction

    // Constant-evaluable power-of-two test used for parameter checks.
    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 32'd1)) == 0);
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module axis_fifo_ram #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/axis_frame_fifo.sv
// AXI Stream FIFO with full-depth occupancy, fill/threshold flags and an
// optional store-and-forward frame mode.
// Build option: define AXIS_FIFO_DROP_BAD_EN to discard errored (tuser[0] on
// tlast) and oversize frames in frame mode instead of passing/force-releasing.
module axis_frame_fifo
    import axis_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned TUSER_WIDTH      = 1,
    parameter int unsigned FIFO_DEPTH       = 32,
    parameter int unsigned FRAME_MODE       = 0,
    parameter int unsigned ALMOST_FULL_LVL  = 28,
    parameter int unsigned ALMOST_EMPTY_LVL = 4
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata_i,
    input  logic                          s_axis_tvalid_i,
    input  logic                          s_axis_tlast_i,
    input  logic [TUSER_WIDTH-1:0]        s_axis_tuser_i,
    output logic                          s_axis_tready_o,
    input  logic                          m_axis_tready_i,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata_o,
    output logic                          m_axis_tvalid_o,
    output logic                          m_axis_tlast_o,
    output logic [TUSER_WIDTH-1:0]        m_axis_tuser_o,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level_o,
    output logic                          almost_full_o,
    output logic                          almost_empty_o,
    output logic                          drop_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned MW = DATA_WIDTH + TUSER_WIDTH + 1;

    // Parameter sanity checks at elaboration.
    if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 4) begin : g_bad_depth
        $error("axis_frame_fifo: FIFO_DEPTH must be a power of two >= 4");
    end
    if (TUSER_WIDTH < 1) begin : g_bad_tuser
        $error("axis_frame_fifo: TUSER_WIDTH must be >= 1");
    end
    if (FRAME_MODE > 1) begin : g_bad_mode
        $error("axis_frame_fifo: FRAME_MODE must be 0 or 1");
    end
    if (ALMOST_FULL_LVL > FIFO_DEPTH || ALMOST_EMPTY_LVL > FIFO_DEPTH) begin : g_bad_lvl
        $error("axis_frame_fifo: threshold levels must not exceed FIFO_DEPTH");
    end

    logic [AW:0]    wr_ptr, wr_ptr_nxt;
    logic [AW:0]    commit_ptr, commit_ptr_nxt;
    logic [AW:0]    rd_ptr;
    logic [AW:0]    used;
    wr_state_e      state, state_nxt;
    logic           full, empty;
    logic           push, wr_en, pop;
    logic           drop_nxt;
    logic [MW-1:0]  wdata, rdata;

    assign used  = PW'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), PW));
    assign full  = (used == PW'(FIFO_DEPTH));
    assign empty = (rd_ptr == commit_ptr);

    // While discarding a frame the slave side must keep draining it.
    assign s_axis_tready_o = (state == WR_DROP) || !full;
    assign push            = s_axis_tvalid_i && s_axis_tready_o;
    assign wr_en           = push && (state == WR_PASS);
    assign m_axis_tvalid_o = !empty;
    assign pop             = m_axis_tvalid_o && m_axis_tready_i;

    assign wdata = {s_axis_tlast_i, s_axis_tuser_i, s_axis_tdata_i};
    assign {m_axis_tlast_o, m_axis_tuser_o, m_axis_tdata_o} = rdata;

    axis_fifo_ram #(
        .WIDTH (MW),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i (wr_ptr[AW-1:0]),
        .wdata_i (wdata),
        .raddr_i (rd_ptr[AW-1:0]),
        .rdata_o (rdata)
    );

    // Next write/commit pointers, write state and drop request.
    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        drop_nxt       = 1'b0;
        if (FRAME_MODE == 0) begin
            if (wr_en) begin
                wr_ptr_nxt = wr_ptr + PW'(1);
            end
            commit_ptr_nxt = wr_ptr_nxt;
        end else begin
            case (state)
                WR_PASS: begin
                    if (wr_en) begin
                        wr_ptr_nxt = wr_ptr + PW'(1);
                        if (s_axis_tlast_i) begin
`ifdef AXIS_FIFO_DROP_BAD_EN
                            if (s_axis_tuser_i[0]) begin
                                wr_ptr_nxt = commit_ptr;
                                drop_nxt   = 1'b1;
                            end else begin
                                commit_ptr_nxt = wr_ptr + PW'(1);
                            end
`else
                            commit_ptr_nxt = wr_ptr + PW'(1);
`endif
                        end
                    end else if (full && (commit_ptr == rd_ptr)) begin
                        // No complete frame stored and no room left: the frame is oversize.
`ifdef AXIS_FIFO_DROP_BAD_EN
                        wr_ptr_nxt = commit_ptr;
                        state_nxt  = WR_DROP;
                        drop_nxt   = 1'b1;
`else
                        commit_ptr_nxt = wr_ptr;
`endif
                    end
                end
                WR_DROP: begin
                    if (push && s_axis_tlast_i) begin
                        state_nxt = WR_PASS;
                    end
                end
                default: state_nxt = WR_PASS;
            endcase
        end
    end

    // Pointer, state and registered status update.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state          <= WR_PASS;
            wr_ptr         <= '0;
            commit_ptr     <= '0;
            rd_ptr         <= '0;
            drop_o         <= 1'b0;
            fill_level_o   <= '0;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
        end else begin
            state          <= state_nxt;
            wr_ptr         <= wr_ptr_nxt;
            commit_ptr     <= commit_ptr_nxt;
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            drop_o         <= drop_nxt;
            fill_level_o   <= used;
            almost_full_o  <= (32'(used) >= ALMOST_FULL_LVL);
            almost_empty_o <= (32'(used) <= ALMOST_EMPTY_LVL);
        end
    end

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Directed + random bench for axis_frame_fifo: one cut-through instance and
// one store-and-forward instance, checked against a queue scoreboard.
module tb_axis_frame_fifo;

    localparam int unsigned DEPTH = 32;

`ifdef AXIS_FIFO_DROP_BAD_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    logic clk_i = 1'b0;
    logic arstn_i;
    always #5 clk_i = ~clk_i;

    logic [7:0] s_tdata_0, s_tdata_1, m_tdata_0, m_tdata_1;
    logic       s_tvalid_0, s_tvalid_1, s_tlast_0, s_tlast_1;
    logic [0:0] s_tuser_0, s_tuser_1, m_tuser_0, m_tuser_1;
    logic       s_tready_0, s_tready_1, m_tready_0, m_tready_1;
    logic       m_tvalid_0, m_tvalid_1, m_tlast_0, m_tlast_1;
    logic [5:0] fill_0, fill_1;
    logic       af_0, af_1, ae_0, ae_1, drop_0, drop_1;
    logic       keep_0, keep_1;

    beat_t q0[$];
    beat_t q1[$];
    int checks = 0;
    int errors = 0;
    int out_cnt_0 = 0, out_cnt_1 = 0, drop_cnt_0 = 0, drop_cnt_1 = 0;

    axis_frame_fifo #(.DATA_WIDTH(8), .TUSER_WIDTH(1), .FIFO_DEPTH(DEPTH), .FRAME_MODE(0),
                      .ALMOST_FULL_LVL(28), .ALMOST_EMPTY_LVL(4)) dut0 (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .s_axis_tdata_i(s_tdata_0), .s_axis_tvalid_i(s_tvalid_0), .s_axis_tlast_i(s_tlast_0),
        .s_axis_tuser_i(s_tuser_0), .s_axis_tready_o(s_tready_0), .m_axis_tready_i(m_tready_0),
        .m_axis_tdata_o(m_tdata_0), .m_axis_tvalid_o(m_tvalid_0), .m_axis_tlast_o(m_tlast_0),
        .m_axis_tuser_o(m_tuser_0), .fill_level_o(fill_0), .almost_full_o(af_0),
        .almost_empty_o(ae_0), .drop_o(drop_0));

    axis_frame_fifo #(.DATA_WIDTH(8), .TUSER_WIDTH(1), .FIFO_DEPTH(DEPTH), .FRAME_MODE(1),
                      .ALMOST_FULL_LVL(28), .ALMOST_EMPTY_LVL(4)) dut1 (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .s_axis_tdata_i(s_tdata_1), .s_axis_tvalid_i(s_tvalid_1), .s_axis_tlast_i(s_tlast_1),
        .s_axis_tuser_i(s_tuser_1), .s_axis_tready_o(s_tready_1), .m_axis_tready_i(m_tready_1),
        .m_axis_tdata_o(m_tdata_1), .m_axis_tvalid_o(m_tvalid_1), .m_axis_tlast_o(m_tlast_1),
        .m_axis_tuser_o(m_tuser_1), .fill_level_o(fill_1), .almost_full_o(af_1),
        .almost_empty_o(ae_1), .drop_o(drop_1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard for the cut-through instance.
    always @(negedge clk_i) begin
        beat_t e0, p0;
        if (arstn_i) begin
            if (m_tvalid_0 && m_tready_0) begin
                checks++;
                assert (q0.size() != 0) else begin
                    errors++;
                    $error("FAIL out0_extra: got beat %0h expected no beat", m_tdata_0);
                end
                if (q0.size() != 0) begin
                    e0 = q0.pop_front();
                    check("out0_beat", 32'({m_tdata_0, m_tlast_0, m_tuser_0}), 32'(e0));
                end
                out_cnt_0++;
            end
            if (s_tvalid_0 && s_tready_0 && keep_0) begin
                p0.d = s_tdata_0; p0.l = s_tlast_0; p0.u = s_tuser_0[0];
                q0.push_back(p0);
            end
            if (drop_0) drop_cnt_0++;
        end
    end

    // Scoreboard for the store-and-forward instance.
    always @(negedge clk_i) begin
        beat_t e1, p1;
        if (arstn_i) begin
            if (m_tvalid_1 && m_tready_1) begin
                checks++;
                assert (q1.size() != 0) else begin
                    errors++;
                    $error("FAIL out1_extra: got beat %0h expected no beat", m_tdata_1);
                end
                if (q1.size() != 0) begin
                    e1 = q1.pop_front();
                    check("out1_beat", 32'({m_tdata_1, m_tlast_1, m_tuser_1}), 32'(e1));
                end
                out_cnt_1++;
            end
            if (s_tvalid_1 && s_tready_1 && keep_1) begin
                p1.d = s_tdata_1; p1.l = s_tlast_1; p1.u = s_tuser_1[0];
                q1.push_back(p1);
            end
            if (drop_1) drop_cnt_1++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_beat(input bit sel, input logic [7:0] d, input logic l,
                             input logic u, input logic k);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        if (sel) begin
            s_tdata_1 = d; s_tlast_1 = l; s_tuser_1 = u; keep_1 = k; s_tvalid_1 = 1'b1;
        end else begin
            s_tdata_0 = d; s_tlast_0 = l; s_tuser_0 = u; keep_0 = k; s_tvalid_0 = 1'b1;
        end
        while (!ok && n < 300) begin
            @(negedge clk_i);
            ok = sel ? s_tready_1 : s_tready_0;
            n++;
        end
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL accept_timeout dut%0d: got ready=0 expected ready=1 within 300 cycles", sel);
        end
        @(posedge clk_i);
        #1;
        if (sel) s_tvalid_1 = 1'b0;
        else     s_tvalid_0 = 1'b0;
    endtask

    task automatic wait_drain(input bit sel);
        int n;
        n = 0;
        while (n < 600 && (sel ? (q1.size() != 0 || m_tvalid_1)
                               : (q0.size() != 0 || m_tvalid_0))) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        assert (n < 600) else begin
            errors++;
            $error("FAIL drain_timeout dut%0d: got pending=%0d expected 0", sel,
                   sel ? q1.size() : q0.size());
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_state(input bit sel);
        string p;
        p = sel ? "rst1" : "rst0";
        check({p, "_tready"}, 32'(sel ? s_tready_1 : s_tready_0), 32'd1);
        check({p, "_tvalid"}, 32'(sel ? m_tvalid_1 : m_tvalid_0), 32'd0);
        check({p, "_fill"},   32'(sel ? fill_1 : fill_0), 32'd0);
        check({p, "_afull"},  32'(sel ? af_1 : af_0), 32'd0);
        check({p, "_aempty"}, 32'(sel ? ae_1 : ae_0), 32'd1);
        check({p, "_drop"},   32'(sel ? drop_1 : drop_0), 32'd0);
    endtask

    initial begin
        int o0, o1, d1, sent, cyc;
        arstn_i = 1'b0;
        s_tdata_0 = '0; s_tvalid_0 = 1'b0; s_tlast_0 = 1'b0; s_tuser_0 = '0; keep_0 = 1'b1;
        s_tdata_1 = '0; s_tvalid_1 = 1'b0; s_tlast_1 = 1'b0; s_tuser_1 = '0; keep_1 = 1'b1;
        m_tready_0 = 1'b0; m_tready_1 = 1'b0;
        idle(3);
        check_reset_state(1'b0);
        check_reset_state(1'b1);
        arstn_i = 1'b1;
        idle(2);

        // Fill the cut-through FIFO to the brim, then drain in order.
        o0 = out_cnt_0;
        for (int i = 0; i < 32; i++) send_beat(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
        s_tdata_0 = 8'hAA; keep_0 = 1'b0; s_tvalid_0 = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            check("t1_tready_full", 32'(s_tready_0), 32'd0);
        end
        check("t1_fill_32", 32'(fill_0), 32'd32);
        check("t1_afull", 32'(af_0), 32'd1);
        check("t1_aempty", 32'(ae_0), 32'd0);
        @(posedge clk_i); #1;
        s_tvalid_0 = 1'b0; keep_0 = 1'b1; m_tready_0 = 1'b1;
        wait_drain(1'b0);
        idle(2);
        check("t1_out_count", 32'(out_cnt_0 - o0), 32'd32);
        check("t1_fill_0", 32'(fill_0), 32'd0);
        check("t1_aempty_end", 32'(ae_0), 32'd1);
        check("t1_afull_end", 32'(af_0), 32'd0);

        // Single-beat latency, then back-to-back streaming.
        m_tready_0 = 1'b0;
        s_tdata_0 = 8'h50; s_tlast_0 = 1'b1; s_tuser_0 = 1'b0; keep_0 = 1'b1; s_tvalid_0 = 1'b1;
        @(negedge clk_i);
        check("t2_valid_before", 32'(m_tvalid_0), 32'd0);
        @(posedge clk_i); #1;
        s_tvalid_0 = 1'b0;
        @(negedge clk_i);
        check("t2_valid_n1", 32'(m_tvalid_0), 32'd1);
        check("t2_data_n1", 32'(m_tdata_0), 32'h50);
        @(posedge clk_i); #1;
        m_tready_0 = 1'b1;
        wait_drain(1'b0);
        for (int i = 0; i < 12; i++) begin
            s_tdata_0 = 8'(96 + i); s_tlast_0 = 1'b0; s_tvalid_0 = 1'b1;
            @(negedge clk_i);
            if (i >= 2) check("t2_fill_steady", 32'(fill_0), 32'd1);
            @(posedge clk_i); #1;
        end
        s_tvalid_0 = 1'b0;
        wait_drain(1'b0);

        // Store-and-forward: nothing visible until the tlast beat is stored.
        o1 = out_cnt_1;
        m_tready_1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_tdata_1 = 8'(16 + i); s_tlast_1 = (i == 4); s_tuser_1 = 1'b0;
            keep_1 = 1'b1; s_tvalid_1 = 1'b1;
            @(negedge clk_i);
            check("t3_valid_low", 32'(m_tvalid_1), 32'd0);
            @(posedge clk_i); #1;
        end
        s_tvalid_1 = 1'b0;
        @(negedge clk_i);
        check("t3_valid_rise", 32'(m_tvalid_1), 32'd1);
        @(posedge clk_i); #1;
        wait_drain(1'b1);
        check("t3_out_count", 32'(out_cnt_1 - o1), 32'd5);

        // Random valid/ready through pointer wrap.
        o0 = out_cnt_0;
        sent = 0;
        cyc = 0;
        while (sent < 100 && cyc < 3000) begin
            s_tdata_0 = 8'(sent);
            s_tlast_0 = ($urandom_range(0, 3) == 0);
            s_tuser_0 = 1'($urandom_range(0, 1));
            keep_0 = 1'b1;
            s_tvalid_0 = 1'($urandom_range(0, 1));
            m_tready_0 = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            check("t4_fill_max", 32'(fill_0 <= 6'd32), 32'd1);
            if (s_tvalid_0 && s_tready_0) sent++;
            @(posedge clk_i); #1;
            cyc++;
        end
        s_tvalid_0 = 1'b0;
        m_tready_0 = 1'b1;
        check("t4_sent", 32'(sent), 32'd100);
        wait_drain(1'b0);
        check("t4_out_count", 32'(out_cnt_0 - o0), 32'd100);

        // Good / errored / good frames.
        o1 = out_cnt_1;
        d1 = drop_cnt_1;
        for (int i = 0; i < 3; i++) send_beat(1'b1, 8'(8'hA0 + i), (i == 2), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_beat(1'b1, 8'(8'hB0 + i), (i == 3), (i == 3), !DROP_EN);
        for (int i = 0; i < 2; i++) send_beat(1'b1, 8'(8'hC0 + i), (i == 1), 1'b0, 1'b1);
        wait_drain(1'b1);
        idle(3);
        check("t5_drops", 32'(drop_cnt_1 - d1), DROP_EN ? 32'd1 : 32'd0);
        check("t5_out_count", 32'(out_cnt_1 - o1), DROP_EN ? 32'd5 : 32'd9);
        check("t5_fill_0", 32'(fill_1), 32'd0);

        // Oversize 40-beat frame followed by a normal frame.
        o1 = out_cnt_1;
        d1 = drop_cnt_1;
        for (int i = 0; i < 40; i++) begin
            send_beat(1'b1, 8'(i), (i == 39), 1'b0, !DROP_EN);
            if (i == 31) check("t6_no_early_out", 32'(out_cnt_1 - o1), 32'd0);
        end
        for (int i = 0; i < 3; i++) send_beat(1'b1, 8'(8'hD0 + i), (i == 2), 1'b0, 1'b1);
        wait_drain(1'b1);
        idle(3);
        check("t6_drops", 32'(drop_cnt_1 - d1), DROP_EN ? 32'd1 : 32'd0);
        check("t6_out_count", 32'(out_cnt_1 - o1), DROP_EN ? 32'd3 : 32'd43);
        check("t6_fill_0", 32'(fill_1), 32'd0);

        // Reset in the middle of partial frames.
        m_tready_0 = 1'b0;
        m_tready_1 = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(1'b0, 8'(8'h70 + i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send_beat(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b1);
        idle(2);
        check("t7_fill_uncommitted", 32'(fill_1), 32'd3);
        check("t7_valid_uncommitted", 32'(m_tvalid_1), 32'd0);
        check("t7_fill_dut0", 32'(fill_0), 32'd3);
        arstn_i = 1'b0;
        #2;
        q0.delete();
        q1.delete();
        check_reset_state(1'b0);
        check_reset_state(1'b1);
        @(posedge clk_i); #1;
        arstn_i = 1'b1;
        m_tready_0 = 1'b1;
        m_tready_1 = 1'b1;
        idle(1);
        o1 = out_cnt_1;
        for (int i = 0; i < 2; i++) send_beat(1'b1, 8'(8'hE0 + i), (i == 1), 1'b0, 1'b1);
        wait_drain(1'b1);
        check("t7_post_reset_out", 32'(out_cnt_1 - o1), 32'd2);

        idle(3);
        check("final_q0_empty", 32'(q0.size()), 32'd0);
        check("final_q1_empty", 32'(q1.size()), 32'd0);
        check("dut0_no_drop", 32'(drop_cnt_0), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
